kbd_mouse_pacer: RTL

Event scheduler between `hid` and the Amiga-side keyboard/mouse receiver. It captures each `kbd_mouse_level` toggle event (type + data) from `hid` into a small FIFO and coalesces back-to-back mouse deltas of the same axis. It then re-issues events on its own toggle interface with a guaranteed minimum spacing, so the slower 7 MHz receiver never misses an event. Keyboard events are never coalesced or reordered.

---
 rtl/kbd_mouse_pacer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/kbd_mouse_pacer.sv
// +------------------------------------------------------------------------------+
// | kbd_mouse_pacer: queues hid toggle events, merges same-axis mouse deltas and |
// | re-issues them on a toggle interface with a minimum spacing. Revision: 1.0   |
// +------------------------------------------------------------------------------+
`default_nettype none

module kbd_mouse_pacer #(
  parameter int DEPTH = 8,
  parameter int GAP   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_level,
  input  logic [1:0]               in_type,
  input  logic [7:0]               in_data,
  output logic                     out_level,
  output logic [1:0]               out_type,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  input  logic                     ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = $clog2(GAP);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [1:0]       mem_type_q [DEPTH];
  logic [7:0]       mem_data_q [DEPTH];

  logic             in_level_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [0:0]       state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             out_level_q, out_level_d;
  logic [1:0]       out_type_q, out_type_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_count_q, drop_count_d;

  logic             evt;
  logic [PTR_W-1:0] tail_ptr;
  logic             do_coalesce;
  logic             do_push;
  logic             do_drop;
  logic             do_pop;
  logic [7:0]       merged_data;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {a[7], a} + {b[7], b};
    if (sum[8] != sum[7]) begin
      sat_add8 = sum[8] ? 8'h80 : 8'h7F;
    end else begin
      sat_add8 = sum[7:0];
    end
  endfunction

  assign evt         = in_level ^ in_level_q;
  assign tail_ptr    = wr_ptr_q - PTR_W'(1);
  // With at least two entries queued the tail can never be the head being popped.
  assign do_coalesce = evt && !in_type[1] && (count_q >= CNT_W'(2)) &&
                       (mem_type_q[tail_ptr] == in_type);
  assign do_push     = evt && !do_coalesce && (count_q < CNT_W'(DEPTH));
  assign do_drop     = evt && !do_coalesce && (count_q >= CNT_W'(DEPTH));
  assign do_pop      = (state_q == ST_IDLE) && (count_q != '0);
  assign merged_data = sat_add8(mem_data_q[tail_ptr], in_data);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    out_level_d  = out_level_q;
    out_type_d   = out_type_q;
    out_data_d   = out_data_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Counter loads GAP-2 so the next pop lands exactly GAP edges after this one.
    case (state_q)
      ST_IDLE: begin
        if (do_pop) begin
          state_d     = ST_WAIT;
          gap_cnt_d   = GAP_W'(GAP - 2);
          out_level_d = ~out_level_q;
          out_type_d  = mem_type_q[rd_ptr_q];
          out_data_d  = mem_data_q[rd_ptr_q];
        end
      end
      default: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
    endcase

    if (ovf_clr) begin
      overflow_d   = 1'b0;
      drop_count_d = 8'd0;
    end else if (do_drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_type_q[wr_ptr_q] <= in_type;
      mem_data_q[wr_ptr_q] <= in_data;
    end else if (do_coalesce) begin
      mem_data_q[tail_ptr] <= merged_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_level_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_IDLE;
      gap_cnt_q    <= '0;
      out_level_q  <= 1'b0;
      out_type_q   <= 2'd0;
      out_data_q   <= 8'd0;
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      in_level_q   <= in_level;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      out_level_q  <= out_level_d;
      out_type_q   <= out_type_d;
      out_data_q   <= out_data_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign out_level  = out_level_q;
  assign out_type   = out_type_q;
  assign out_data   = out_data_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

`default_nettype wire
